ma_arbiter: RTL and testbench

MA_ARBITER -- requirements
Module: ma_arbiter

---
 rtl/fc_pkg.sv | 17 +
 rtl/ma_tag_pipe.sv | 44 ++++
 rtl/ma_arbiter.sv | 153 +++++++++++++++
 tb/tb_ma_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared defaults and types for the MultAdder arbiter and its tag pipe.
package fc_pkg;
  localparam int BIT_DEFAULT   = 8;
  localparam int LANES_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/ma_tag_pipe.sv
// Valid/id delay line that follows each MultAdder operation from
// arbitration to the cycle its result appears on ma_result.
module ma_tag_pipe
  import fc_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    iRst,
  input  logic    i_valid,
  input  req_id_t i_id,
  output logic    o_valid,
  output req_id_t o_id
);
  logic [DEPTH:0] w_valid;
  logic [DEPTH:0] w_id;

  assign w_valid[0] = i_valid;
  assign w_id[0]    = i_id;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic    r_valid;
      req_id_t r_id;

      always_ff @(posedge clk) begin
        if (iRst) begin
          r_valid <= 1'b0;
          r_id    <= 1'b0;
        end else begin
          r_valid <= w_valid[gi];
          r_id    <= w_id[gi];
        end
      end

      assign w_valid[gi+1] = r_valid;
      assign w_id[gi+1]    = r_id;
    end
  endgenerate

  assign o_valid = w_valid[DEPTH];
  assign o_id    = w_id[DEPTH];
endmodule

// File: rtl/ma_arbiter.sv
// Two-requester round-robin arbiter with burst locking in front of a shared
// MultAdder. Define MA_ARB_CNT_EN to add saturating per-requester issue counters.
module ma_arbiter
  import fc_pkg::*;
#(
  parameter int BIT    = BIT_DEFAULT,
  parameter int LANES  = LANES_DEFAULT,
  parameter int MA_LAT = 2
) (
  input  logic                   clk,
  input  logic                   iRst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   lock0,
  input  logic                   lock1,
  input  logic [LANES*BIT-1:0]   opr1_0,
  input  logic [LANES*BIT-1:0]   opr2_0,
  input  logic [LANES*BIT-1:0]   opr1_1,
  input  logic [LANES*BIT-1:0]   opr2_1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic [2*BIT-2:0]       result,
  output logic                   ovf,
`ifdef MA_ARB_CNT_EN
  output logic [15:0]            cnt0,
  output logic [15:0]            cnt1,
`endif
  output logic [LANES*BIT-1:0]   ma_opr1,
  output logic [LANES*BIT-1:0]   ma_opr2,
  output logic                   ma_issue,
  input  logic [2*BIT-2:0]       ma_result,
  input  logic                   ma_overflow
);
  arb_state_t             r_state;
  arb_state_t             w_state_next;
  req_id_t                r_ptr;
  logic                   r_gnt0, r_gnt1, r_issue;
  logic [LANES*BIT-1:0]   r_opr1, r_opr2;
  logic                   r_rvalid0, r_rvalid1, r_ovf;
  logic [2*BIT-2:0]       r_result;
  logic                   w_gnt0, w_gnt1;
  logic                   w_tag_valid;
  req_id_t                w_tag_id;

  // A held lock bypasses round-robin; any other cycle arbitrates as IDLE.
  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_state_next = IDLE;
    if (r_state == LOCK0 && lock0) begin
      w_gnt0       = req0;
      w_state_next = LOCK0;
    end else if (r_state == LOCK1 && lock1) begin
      w_gnt1       = req1;
      w_state_next = LOCK1;
    end else begin
      if (req0 && req1) begin
        w_gnt0 = r_ptr;
        w_gnt1 = ~r_ptr;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
      if (w_gnt0 && lock0)
        w_state_next = LOCK0;
      else if (w_gnt1 && lock1)
        w_state_next = LOCK1;
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_issue <= 1'b0;
      r_opr1  <= '0;
      r_opr2  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_issue <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_ptr  <= 1'b0;
        r_opr1 <= opr1_0;
        r_opr2 <= opr2_0;
      end else if (w_gnt1) begin
        r_ptr  <= 1'b1;
        r_opr1 <= opr1_1;
        r_opr2 <= opr2_1;
      end
    end
  end

  // Tag enters at arbitration so its tail lines up with ma_result of that op.
  ma_tag_pipe #(
    .DEPTH (MA_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .iRst    (iRst),
    .i_valid (w_gnt0 | w_gnt1),
    .i_id    (w_gnt1),
    .o_valid (w_tag_valid),
    .o_id    (w_tag_id)
  );

  always_ff @(posedge clk) begin
    if (iRst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_rvalid0 <= w_tag_valid && (w_tag_id == 1'b0);
      r_rvalid1 <= w_tag_valid && (w_tag_id == 1'b1);
      if (w_tag_valid) begin
        r_result <= ma_result;
        r_ovf    <= ma_overflow;
      end
    end
  end

`ifdef MA_ARB_CNT_EN
  logic [15:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk) begin
    if (iRst) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else begin
      if (w_gnt0) r_cnt0 <= sat_inc16(r_cnt0);
      if (w_gnt1) r_cnt1 <= sat_inc16(r_cnt1);
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign ma_issue = r_issue;
  assign ma_opr1  = r_opr1;
  assign ma_opr2  = r_opr2;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign result   = r_result;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_ma_arbiter.sv
// Scoreboard bench for ma_arbiter with a behavioural MultAdder (dot product,
// overflow when the sum does not fit the result width). Counter test needs MA_ARB_CNT_EN.
`timescale 1ns/1ps
module tb_ma_arbiter;
  localparam int BIT    = 8;
  localparam int LANES  = 4;
  localparam int MA_LAT = 2;
  localparam int W      = LANES * BIT;
  localparam int RW     = 2 * BIT - 1;

  logic          clk = 1'b0;
  logic          iRst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [W-1:0]  opr1_0, opr2_0, opr1_1, opr2_1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ovf, ma_issue;
  logic [RW-1:0] result, ma_result;
  logic [W-1:0]  ma_opr1, ma_opr2;
  logic          ma_overflow;
`ifdef MA_ARB_CNT_EN
  logic [15:0]   cnt0, cnt1;
`endif

  typedef struct {
    int          id;
    logic [RW:0] exp;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n0 = 0, n1 = 0;
  int   en0 = 0, en1 = 0;
  int   ovf_idx = -1;
  bit   quiet = 1'b0;
  logic [RW:0] ma_pipe [MA_LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ma_arbiter #(.BIT(BIT), .LANES(LANES), .MA_LAT(MA_LAT)) dut (
    .clk(clk), .iRst(iRst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .opr1_0(opr1_0), .opr2_0(opr2_0), .opr1_1(opr1_1), .opr2_1(opr2_1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .result(result), .ovf(ovf),
`ifdef MA_ARB_CNT_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .ma_opr1(ma_opr1), .ma_opr2(ma_opr2), .ma_issue(ma_issue),
    .ma_result(ma_result), .ma_overflow(ma_overflow)
  );

  function automatic logic [RW:0] mac(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < LANES; i++)
      sum += 32'(a[i*BIT +: BIT]) * 32'(b[i*BIT +: BIT]);
    return {(sum >= 32'(1 << RW)), sum[RW-1:0]};
  endfunction

  function automatic logic [7:0] gen_a(input int k, input int n);
    if (k == 0 && n == 0) return 8'h40;
    if (k == 1 && n == ovf_idx) return 8'hF0;
    return 8'((n * 7 + k * 20 + 3) & 63);
  endfunction

  function automatic logic [7:0] gen_b(input int k, input int n);
    if (k == 0 && n == 0) return 8'h20;
    if (k == 1 && n == ovf_idx) return 8'hF0;
    return 8'((n * 5 + k * 11 + 1) & 63);
  endfunction

  // MultAdder model: result in cycle c reflects ma_opr of cycle c-MA_LAT.
  always @(posedge clk) begin
    ma_pipe[0] <= mac(ma_opr1, ma_opr2);
    for (int i = 1; i < MA_LAT; i++) ma_pipe[i] <= ma_pipe[i-1];
  end
  assign ma_result   = ma_pipe[MA_LAT-1][RW-1:0];
  assign ma_overflow = ma_pipe[MA_LAT-1][RW];

  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      checks++;
      if (rvalid0 && rvalid1) begin
        failures++;
        $display("FAIL both_rvalid cyc=%0d rvalid0=%b rvalid1=%b required one-hot", cyc, rvalid0, rvalid1);
      end else if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid cyc=%0d rvalid0=%b rvalid1=%b result=%h required no rvalid",
                 cyc, rvalid0, rvalid1, result);
      end else begin
        mon_e = sbq.pop_front();
        if ((rvalid1 ? 1 : 0) != mon_e.id || {ovf, result} !== mon_e.exp || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL result cyc=%0d id=%0d ovf=%b result=%h required cyc=%0d id=%0d ovf=%b result=%h",
                   cyc, rvalid1 ? 1 : 0, ovf, result, mon_e.cyc, mon_e.id, mon_e.exp[RW], mon_e.exp[RW-1:0]);
        end else if (!quiet) begin
          $display("rvalid cyc=%0d id=%0d result=%h ovf=%b ok", cyc, mon_e.id, result, ovf);
        end
      end
    end
  end

  task automatic set_oprs();
    opr1_0 = {LANES{gen_a(0, n0)}};
    opr2_0 = {LANES{gen_b(0, n0)}};
    opr1_1 = {LANES{gen_a(1, n1)}};
    opr2_1 = {LANES{gen_b(1, n1)}};
  endtask

  // One arbitration cycle; win = expected winner (0, 1, or 2 for none).
  task automatic step(input logic r0, input logic r1, input logic l0, input logic l1,
                      input int win, input bit push);
    exp_t e;
    req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
    if (push && win == 0) begin
      e.id = 0; e.exp = mac({LANES{gen_a(0, en0)}}, {LANES{gen_b(0, en0)}}); e.cyc = cyc + MA_LAT + 2;
      sbq.push_back(e);
    end
    if (push && win == 1) begin
      e.id = 1; e.exp = mac({LANES{gen_a(1, en1)}}, {LANES{gen_b(1, en1)}}); e.cyc = cyc + MA_LAT + 2;
      sbq.push_back(e);
    end
    if (win == 0) en0++;
    if (win == 1) en1++;
    @(posedge clk); #1;
    checks++;
    if (gnt0 !== (win == 0) || gnt1 !== (win == 1) || ma_issue !== (win != 2)) begin
      failures++;
      $display("FAIL grant cyc=%0d gnt0=%b gnt1=%b ma_issue=%b required winner=%0d", cyc, gnt0, gnt1, ma_issue, win);
    end
    if (gnt0) n0++;
    if (gnt1) n1++;
    set_oprs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ma_issue, ovf} !== 6'b0 || result !== '0 ||
        ma_opr1 !== '0 || ma_opr2 !== '0) begin
      failures++;
      $display("FAIL %s cyc=%0d flags=%b result=%h ma_opr1=%h ma_opr2=%h required all zero",
               tag, cyc, {gnt0, gnt1, rvalid0, rvalid1, ma_issue, ovf}, result, ma_opr1, ma_opr2);
    end
  endtask

  task automatic do_reset(input logic hold_req0, input string tag);
    iRst = 1'b1; req0 = hold_req0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    @(posedge clk); #1;
    iRst = 1'b0;
    check_reset_vals(tag);
  endtask

  initial begin
    set_oprs();
    do_reset(1'b0, "reset_init");

    // Lone req0 with 0x40 x 0x20 operands.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(5);
    checks++;
    if (result !== 15'h2000 || ovf !== 1'b0 || ma_opr1 !== 32'h40404040 || ma_opr2 !== 32'h20202020) begin
      failures++;
      $display("FAIL lone_req0 result=%h ovf=%b ma_opr1=%h ma_opr2=%h required 2000 0 40404040 20202020",
               result, ovf, ma_opr1, ma_opr2);
    end

    // Both requesting continuously after reset: strict alternation from 0.
    do_reset(1'b0, "reset_pre_rr");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, i % 2, 1'b1);
    idle(5);

    // Locked burst of 8 on requester 0 (with one no-request gap), lock1 ignored.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    idle(5);

    // Overflow on the middle op of three from requester 1.
    ovf_idx = en1 + 1;
    set_oprs();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    idle(5);
    ovf_idx = -1;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_hold ovf=%b required 0", ovf);
    end

    // Reset with three ops in flight; req0 held through reset must be ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_reset(1'b1, "reset_flush");
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(6);

`ifdef MA_ARB_CNT_EN
    do_reset(1'b0, "reset_cnt");
    quiet = 1'b1;
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    idle(5);
    quiet = 1'b0;
    checks++;
    if (cnt1 !== 16'hFFFF || cnt0 !== 16'h0000) begin
      failures++;
      $display("FAIL counters cnt0=%h cnt1=%h required 0000 FFFF", cnt0, cnt1);
    end
`endif

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
